// File: rtl/image_window_capture.sv
// Avalon-MM slave that carries VGA luma samples into the clk domain, exposes the live
// pixel in 24.8 fixed point, and captures a programmed rectangular window of one frame.
module image_window_capture #(
    parameter int PIX_W   = 8,
    parameter int COORD_W = 11,
    parameter int DEPTH   = 256,
    parameter int ADDR_W  = 9
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [ADDR_W-1:0]  addr,
    input  logic               rd_en,
    input  logic               wr_en,
    output logic [31:0]        readdata,
    input  logic [31:0]        writedata,
    input  logic               vga_clk,
    input  logic               vga_valid,
    input  logic [PIX_W-1:0]   vga_pixel,
    input  logic [COORD_W-1:0] vga_x,
    input  logic [COORD_W-1:0] vga_y
);
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int IDX_W  = ADDR_W - 1;
    localparam int SMP_W  = PIX_W + 2 * COORD_W;

    typedef enum logic [1:0] {IDLE, WAIT_SOF, CAPTURE, DONE} state_t;

    logic [SMP_W-1:0] hold_q, hold_d;
    logic             tog_q, tog_d;

    always_comb begin
        hold_d = hold_q;
        tog_d  = tog_q;
        if (vga_valid) begin
            hold_d = {vga_pixel, vga_x, vga_y};
            tog_d  = ~tog_q;
        end
    end

    always_ff @(posedge vga_clk) begin
        hold_q <= hold_d;
        tog_q  <= tog_d;
    end

    logic [2:0]         sync_q, sync_d;
    logic               smp_q, smp_d;
    logic [SMP_W-1:0]   sample_q, sample_d;
    state_t             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               done_q, done_d;
    logic               overflow_q, overflow_d;
    logic [COORD_W-1:0] x0_q, x0_d, x1_q, x1_d, y0_q, y0_d, y1_q, y1_d;
    logic [31:0]        readdata_q, readdata_d;
    logic               mem_we;
    logic [PIX_W-1:0]   mem [DEPTH];

    // hold_q is stable for a full vga_clk period after the toggle flips, so it is safe
    // to copy once the toggle edge has crossed the synchroniser.
    logic sync_edge;
    assign sync_edge = sync_q[1] ^ sync_q[2];

    always_comb begin
        sync_d   = {sync_q[1:0], tog_q};
        smp_d    = sync_edge;
        sample_d = sync_edge ? hold_q : sample_q;
    end

    logic [PIX_W-1:0]   smp_pix;
    logic [COORD_W-1:0] smp_x, smp_y;
    assign smp_pix = sample_q[SMP_W-1 -: PIX_W];
    assign smp_x   = sample_q[2*COORD_W-1 -: COORD_W];
    assign smp_y   = sample_q[COORD_W-1:0];

    logic busy, sof, hit, reg_sel, ctrl_wr;
    logic [IDX_W-1:0] reg_idx;
    assign busy    = (state_q == WAIT_SOF) || (state_q == CAPTURE);
    assign sof     = smp_q && (smp_x == '0) && (smp_y == '0);
    assign hit     = smp_q && (smp_x >= x0_q) && (smp_x <= x1_q)
                           && (smp_y >= y0_q) && (smp_y <= y1_q);
    assign reg_sel = ~addr[ADDR_W-1];
    assign reg_idx = addr[IDX_W-1:0];
    assign ctrl_wr = wr_en && reg_sel && (reg_idx == IDX_W'(0));

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        done_d     = done_q;
        overflow_d = overflow_q;
        mem_we     = 1'b0;
        x0_d = x0_q;
        x1_d = x1_q;
        y0_d = y0_q;
        y1_d = y1_q;
        if (wr_en && reg_sel && !busy && (reg_idx == IDX_W'(2))) begin
            x0_d = writedata[COORD_W-1:0];
            x1_d = writedata[16+COORD_W-1:16];
        end
        if (wr_en && reg_sel && !busy && (reg_idx == IDX_W'(3))) begin
            y0_d = writedata[COORD_W-1:0];
            y1_d = writedata[16+COORD_W-1:16];
        end
        // A CTRL write owns the cycle; any sample arriving alongside it is dropped.
        if (ctrl_wr) begin
            if (writedata[1]) begin
                state_d = IDLE;
                done_d  = 1'b0;
            end else if (writedata[0]) begin
                state_d    = WAIT_SOF;
                count_d    = '0;
                done_d     = 1'b0;
                overflow_d = 1'b0;
            end
        end else begin
            unique case (state_q)
                WAIT_SOF: begin
                    if (sof) begin
                        state_d = CAPTURE;
                        if (hit) begin
                            mem_we  = 1'b1;
                            count_d = count_q + CNT_W'(1);
                        end
                    end
                end
                CAPTURE: begin
                    if (sof) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else if (hit) begin
                        if (32'(count_q) < DEPTH) begin
                            mem_we  = 1'b1;
                            count_d = count_q + CNT_W'(1);
                        end else begin
                            overflow_d = 1'b1;
                            state_d    = DONE;
                            done_d     = 1'b1;
                        end
                    end else if (smp_q && (smp_y > y1_q)) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        readdata_d = '0;
        if (rd_en) begin
            if (reg_sel) begin
                case (reg_idx)
                    IDX_W'(0): readdata_d = {31'b0, busy};
                    IDX_W'(1): readdata_d = (32'(count_q) << 16) | {30'b0, overflow_q, done_q};
                    IDX_W'(2): readdata_d = (32'(x1_q) << 16) | 32'(x0_q);
                    IDX_W'(3): readdata_d = (32'(y1_q) << 16) | 32'(y0_q);
                    IDX_W'(4): readdata_d = 32'({smp_pix, 8'b0});
                    default:   readdata_d = '0;
                endcase
            end else if (32'(reg_idx) < DEPTH) begin
                readdata_d = 32'({mem[reg_idx[MEM_AW-1:0]], 8'b0});
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync_q     <= '0;
            smp_q      <= 1'b0;
            sample_q   <= '0;
            state_q    <= IDLE;
            count_q    <= '0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
            x0_q       <= '0;
            x1_q       <= '0;
            y0_q       <= '0;
            y1_q       <= '0;
            readdata_q <= '0;
        end else begin
            sync_q     <= sync_d;
            smp_q      <= smp_d;
            sample_q   <= sample_d;
            state_q    <= state_d;
            count_q    <= count_d;
            done_q     <= done_d;
            overflow_q <= overflow_d;
            x0_q       <= x0_d;
            x1_q       <= x1_d;
            y0_q       <= y0_d;
            y1_q       <= y1_d;
            readdata_q <= readdata_d;
        end
    end

    // Buffer contents deliberately survive reset and ABORT.
    always_ff @(posedge clk) begin
        if (mem_we) mem[count_q[MEM_AW-1:0]] <= smp_pix;
    end

    assign readdata = readdata_q;

    logic unused_wdata;
    assign unused_wdata = ^writedata;
endmodule

// File: tb/tb_image_window_capture.sv
// Directed self-checking bench for image_window_capture; a DEPTH=4 copy shares the
// bus and pixel stream so buffer overflow can be exercised with a tiny frame.
module tb_image_window_capture;
    logic        clk = 1'b0;
    logic        vga_clk = 1'b0;
    logic        reset_n;
    logic [8:0]  addr;
    logic        rd_en, wr_en;
    logic [31:0] writedata, readdata, readdata4;
    logic        vga_valid;
    logic [7:0]  vga_pixel;
    logic [10:0] vga_x, vga_y;

    int n_cmp = 0;
    int n_fail = 0;
    logic [31:0] rd, rd4;

    image_window_capture #(.PIX_W(8), .COORD_W(11), .DEPTH(256), .ADDR_W(9)) dut (
        .clk(clk), .reset_n(reset_n), .addr(addr), .rd_en(rd_en), .wr_en(wr_en),
        .readdata(readdata), .writedata(writedata), .vga_clk(vga_clk),
        .vga_valid(vga_valid), .vga_pixel(vga_pixel), .vga_x(vga_x), .vga_y(vga_y));

    image_window_capture #(.PIX_W(8), .COORD_W(11), .DEPTH(4), .ADDR_W(9)) dut4 (
        .clk(clk), .reset_n(reset_n), .addr(addr), .rd_en(rd_en), .wr_en(wr_en),
        .readdata(readdata4), .writedata(writedata), .vga_clk(vga_clk),
        .vga_valid(vga_valid), .vga_pixel(vga_pixel), .vga_x(vga_x), .vga_y(vga_y));

    always #5 clk = ~clk;
    initial begin
        #3;
        forever #40 vga_clk = ~vga_clk;
    end

    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic av_write(input logic [8:0] a, input logic [31:0] d);
        @(negedge clk);
        addr = a; writedata = d; wr_en = 1'b1;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic av_read(input logic [8:0] a, output logic [31:0] d, output logic [31:0] d4);
        @(negedge clk);
        addr = a; rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        d = readdata;
        d4 = readdata4;
    endtask

    // 16x8 frame; mode 0: pixel=x+y, mode 1: constant 0xAB, mode 2: pixel=0x40+x
    task automatic send_frame(input int mode);
        for (int y = 0; y < 8; y++) begin
            for (int x = 0; x < 16; x++) begin
                @(negedge vga_clk);
                vga_valid = 1'b1;
                vga_x = 11'(x);
                vga_y = 11'(y);
                vga_pixel = (mode == 0) ? 8'(x + y) : (mode == 1) ? 8'hAB : 8'(8'h40 + x);
            end
        end
        @(negedge vga_clk);
        vga_valid = 1'b0;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        wait_clk(4);
        n_cmp++;
        if (readdata !== 32'h0) begin
            n_fail++;
            $display("[TB] FAIL reset_readdata: got %h expected %h", readdata, 32'h0);
        end
        reset_n = 1'b1;
        wait_clk(2);
        for (int a = 0; a < 5; a++) begin
            av_read(9'(a), rd, rd4);
            n_cmp++;
            if (rd !== 32'h0) begin
                n_fail++;
                $display("[TB] FAIL reset_reg%0d: got %h expected %h", a, rd, 32'h0);
            end
        end
    endtask

    task automatic test_single_pixel;
        av_write(9'd2, 32'h0005_0005);
        av_write(9'd3, 32'h0002_0002);
        av_write(9'd0, 32'h1);
        send_frame(0);
        wait_clk(10);
        av_read(9'd1, rd, rd4);
        n_cmp++;
        if (rd !== 32'h0001_0001) begin
            n_fail++;
            $display("[TB] FAIL single_status: got %h expected %h", rd, 32'h0001_0001);
        end
        av_read(9'd256, rd, rd4);
        n_cmp++;
        if (rd !== 32'h0000_0700) begin
            n_fail++;
            $display("[TB] FAIL single_buf0: got %h expected %h", rd, 32'h0000_0700);
        end
        av_read(9'd0, rd, rd4);
        n_cmp++;
        if (rd !== 32'h0) begin
            n_fail++;
            $display("[TB] FAIL single_busy: got %h expected %h", rd, 32'h0);
        end
    endtask

    task automatic test_mid_frame_arm;
        logic [31:0] exp;
        av_write(9'd2, 32'h000D_000A);
        av_write(9'd3, 32'h0004_0003);
        fork
            begin
                send_frame(0);
                send_frame(0);
            end
            begin
                wait_clk(600);
                av_write(9'd0, 32'h1);
                av_read(9'd0, rd, rd4);
                n_cmp++;
                if (rd !== 32'h1) begin
                    n_fail++;
                    $display("[TB] FAIL mid_busy: got %h expected %h", rd, 32'h1);
                end
                av_read(9'd1, rd, rd4);
                n_cmp++;
                if (rd !== 32'h0) begin
                    n_fail++;
                    $display("[TB] FAIL mid_status_wait: got %h expected %h", rd, 32'h0);
                end
            end
        join
        wait_clk(10);
        av_read(9'd1, rd, rd4);
        n_cmp++;
        if (rd !== 32'h0008_0001) begin
            n_fail++;
            $display("[TB] FAIL mid_status: got %h expected %h", rd, 32'h0008_0001);
        end
        for (int i = 0; i < 8; i++) begin
            exp = (i < 4) ? 32'((3 + 10 + i) << 8) : 32'((4 + 10 + i - 4) << 8);
            av_read(9'(256 + i), rd, rd4);
            n_cmp++;
            if (rd !== exp) begin
                n_fail++;
                $display("[TB] FAIL mid_buf%0d: got %h expected %h", i, rd, exp);
            end
        end
    endtask

    task automatic test_overflow;
        logic [31:0] exp;
        av_write(9'd2, 32'h0009_0000);
        av_write(9'd3, 32'h0000_0000);
        av_write(9'd0, 32'h1);
        send_frame(2);
        wait_clk(10);
        av_read(9'd1, rd, rd4);
        n_cmp++;
        if (rd4 !== 32'h0004_0003) begin
            n_fail++;
            $display("[TB] FAIL ovf_status4: got %h expected %h", rd4, 32'h0004_0003);
        end
        n_cmp++;
        if (rd !== 32'h000A_0001) begin
            n_fail++;
            $display("[TB] FAIL ovf_status256: got %h expected %h", rd, 32'h000A_0001);
        end
        for (int i = 0; i < 4; i++) begin
            exp = 32'((8'h40 + i) << 8);
            av_read(9'(256 + i), rd, rd4);
            n_cmp++;
            if (rd4 !== exp) begin
                n_fail++;
                $display("[TB] FAIL ovf_buf4_%0d: got %h expected %h", i, rd4, exp);
            end
        end
        av_read(9'd260, rd, rd4);
        n_cmp++;
        if (rd4 !== 32'h0) begin
            n_fail++;
            $display("[TB] FAIL ovf_beyond_depth: got %h expected %h", rd4, 32'h0);
        end
        av_read(9'd265, rd, rd4);
        n_cmp++;
        if (rd !== 32'h0000_4900) begin
            n_fail++;
            $display("[TB] FAIL ovf_buf256_9: got %h expected %h", rd, 32'h0000_4900);
        end
    endtask

    task automatic test_abort;
        av_write(9'd2, 32'h0004_0002);
        av_write(9'd3, 32'h0002_0001);
        av_write(9'd0, 32'h1);
        av_write(9'd2, 32'h0007_0007);
        av_read(9'd2, rd, rd4);
        n_cmp++;
        if (rd !== 32'h0004_0002) begin
            n_fail++;
            $display("[TB] FAIL abort_xwin_busy: got %h expected %h", rd, 32'h0004_0002);
        end
        fork
            send_frame(0);
            begin
                wait_clk(220);
                av_write(9'd0, 32'h2);
            end
        join
        wait_clk(10);
        av_read(9'd0, rd, rd4);
        n_cmp++;
        if (rd !== 32'h0) begin
            n_fail++;
            $display("[TB] FAIL abort_busy: got %h expected %h", rd, 32'h0);
        end
        av_read(9'd1, rd, rd4);
        n_cmp++;
        if (rd !== 32'h0003_0000) begin
            n_fail++;
            $display("[TB] FAIL abort_status: got %h expected %h", rd, 32'h0003_0000);
        end
        for (int i = 0; i < 3; i++) begin
            av_read(9'(256 + i), rd, rd4);
            n_cmp++;
            if (rd !== 32'((3 + i) << 8)) begin
                n_fail++;
                $display("[TB] FAIL abort_buf%0d: got %h expected %h", i, rd, 32'((3 + i) << 8));
            end
        end
        av_write(9'd2, 32'h0007_0007);
        av_read(9'd2, rd, rd4);
        n_cmp++;
        if (rd !== 32'h0007_0007) begin
            n_fail++;
            $display("[TB] FAIL abort_xwin_idle: got %h expected %h", rd, 32'h0007_0007);
        end
    endtask

    task automatic test_live;
        send_frame(1);
        wait_clk(10);
        av_read(9'd4, rd, rd4);
        n_cmp++;
        if (rd !== 32'h0000_AB00) begin
            n_fail++;
            $display("[TB] FAIL live: got %h expected %h", rd, 32'h0000_AB00);
        end
        @(negedge clk);
        n_cmp++;
        if (readdata !== 32'h0) begin
            n_fail++;
            $display("[TB] FAIL read_idle: got %h expected %h", readdata, 32'h0);
        end
        av_read(9'd5, rd, rd4);
        n_cmp++;
        if (rd !== 32'h0) begin
            n_fail++;
            $display("[TB] FAIL unused_reg: got %h expected %h", rd, 32'h0);
        end
        av_write(9'd0, 32'h3);
        av_read(9'd0, rd, rd4);
        n_cmp++;
        if (rd !== 32'h0) begin
            n_fail++;
            $display("[TB] FAIL arm_abort_busy: got %h expected %h", rd, 32'h0);
        end
        av_read(9'd1, rd, rd4);
        n_cmp++;
        if (rd !== 32'h0003_0000) begin
            n_fail++;
            $display("[TB] FAIL arm_abort_status: got %h expected %h", rd, 32'h0003_0000);
        end
    endtask

    task automatic test_reset_midcapture;
        av_write(9'd2, 32'h000F_0000);
        av_write(9'd3, 32'h0007_0000);
        av_write(9'd0, 32'h1);
        fork
            send_frame(0);
            begin
                wait_clk(400);
                reset_n = 1'b0;
                wait_clk(2);
                reset_n = 1'b1;
            end
        join
        wait_clk(10);
        av_read(9'd1, rd, rd4);
        n_cmp++;
        if (rd !== 32'h0) begin
            n_fail++;
            $display("[TB] FAIL rst_status: got %h expected %h", rd, 32'h0);
        end
        av_read(9'd0, rd, rd4);
        n_cmp++;
        if (rd !== 32'h0) begin
            n_fail++;
            $display("[TB] FAIL rst_busy: got %h expected %h", rd, 32'h0);
        end
        av_read(9'd2, rd, rd4);
        n_cmp++;
        if (rd !== 32'h0) begin
            n_fail++;
            $display("[TB] FAIL rst_xwin: got %h expected %h", rd, 32'h0);
        end
        av_read(9'd257, rd, rd4);
        n_cmp++;
        if (rd !== 32'h0000_0100) begin
            n_fail++;
            $display("[TB] FAIL rst_buf_kept: got %h expected %h", rd, 32'h0000_0100);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        addr = '0;
        rd_en = 1'b0;
        wr_en = 1'b0;
        writedata = '0;
        vga_valid = 1'b0;
        vga_pixel = '0;
        vga_x = '0;
        vga_y = '0;
        test_reset;
        test_single_pixel;
        test_mid_frame_arm;
        test_overflow;
        test_abort;
        test_live;
        test_reset_midcapture;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
